// File: rtl/spi_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : spi_receiver
//  Purpose  : SD-card MISO deserializer: hunts for the response start bit,
//             shifts DATA_BITS bits MSB-first, flags a timeout if none arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_receiver #(
    parameter int DATA_BITS = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk_posedge,
    input  logic                 en,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 timed_out,
    output logic                 done
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] c_last_bit     = BCW'(DATA_BITS - 1);
    localparam logic [TCW-1:0] c_timeout_load = TCW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_RECEIVE    = 2'd2
    } state_t;

    state_t               r_state,     w_state;
    logic [DATA_BITS-1:0] r_shreg,     w_shreg;
    logic [DATA_BITS-1:0] r_data,      w_data;
    logic [BCW-1:0]       r_bit_cnt,   w_bit_cnt;
    logic [TCW-1:0]       r_to_cnt,    w_to_cnt;
    logic                 r_valid,     w_valid;
    logic                 r_timed_out, w_timed_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_data      <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_valid     <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_shreg     <= w_shreg;
            r_data      <= w_data;
            r_bit_cnt   <= w_bit_cnt;
            r_to_cnt    <= w_to_cnt;
            r_valid     <= w_valid;
            r_timed_out <= w_timed_out;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_shreg     = r_shreg;
        w_data      = r_data;
        w_bit_cnt   = r_bit_cnt;
        w_to_cnt    = r_to_cnt;
        w_valid     = 1'b0;
        w_timed_out = r_timed_out;

        case (r_state)
            S_IDLE: begin
                // A strobe coincident with en is deliberately not sampled here.
                if (en) begin
                    w_timed_out = 1'b0;
                    w_to_cnt    = c_timeout_load;
                    w_shreg     = '0;
                    w_bit_cnt   = '0;
                    w_state     = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (sclk_posedge) begin
                    if (!in) begin
                        w_shreg   = {r_shreg[DATA_BITS-2:0], 1'b0};
                        w_bit_cnt = BCW'(1);
                        w_state   = S_RECEIVE;
                    end else begin
                        w_to_cnt = r_to_cnt - 1'b1;
                        if (r_to_cnt == TCW'(1)) begin
                            w_timed_out = 1'b1;
                            w_state     = S_IDLE;
                        end
                    end
                end
            end
            S_RECEIVE: begin
                if (sclk_posedge) begin
                    w_shreg   = {r_shreg[DATA_BITS-2:0], in};
                    w_bit_cnt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_data  = {r_shreg[DATA_BITS-2:0], in};
                        w_valid = 1'b1;
                        w_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign timed_out = r_timed_out;
    assign done      = (r_state == S_IDLE) && !en;

endmodule
`default_nettype wire

// File: tb/tb_spi_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_receiver
//  Purpose  : Directed + randomized self-checking bench for spi_receiver
//             (8-bit and 40-bit instances, TIMEOUT = 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_receiver;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset, sclk_posedge, en8, en40, miso;
    logic [7:0]  data8;
    logic [39:0] data40;
    logic        valid8, to8, done8, valid40, to40, done40;

    int vectors = 0, miscompares = 0;
    int vcnt8 = 0, vcnt40 = 0;

    bit          stim[$];
    logic [39:0] exp_data8 = '0, exp_data40 = '0;
    bit          exp_to8 = 0, exp_to40 = 0;

    spi_receiver #(.DATA_BITS(8), .TIMEOUT(TO)) dut8 (
        .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .en(en8), .in(miso),
        .data(data8), .valid(valid8), .timed_out(to8), .done(done8));

    spi_receiver #(.DATA_BITS(40), .TIMEOUT(TO)) dut40 (
        .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .en(en40), .in(miso),
        .data(data40), .valid(valid40), .timed_out(to40), .done(done40));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid8)  vcnt8++;
        if (valid40) vcnt40++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: skip up to TO leading ones, then the next db samples form the word.
    function automatic void model(input int db, inout logic [39:0] d, output bit to,
                                  output int nvalid);
        int i = 0;
        int ones = 0;
        to = 0;
        nvalid = 0;
        while (i < stim.size() && stim[i] == 1'b1 && ones < TO) begin
            ones++;
            i++;
        end
        if (ones == TO) begin
            to = 1;
        end else if (stim.size() - i >= db) begin
            d = '0;
            for (int k = 0; k < db; k++) d = {d[38:0], stim[i+k]};
            nvalid = 1;
        end
    endfunction

    task automatic build(input int ones, input logic [39:0] w, input int db);
        stim = {};
        repeat (ones) stim.push_back(1'b1);
        if (ones < TO)
            for (int k = db - 1; k >= 0; k--) stim.push_back(w[k]);
    endtask

    task automatic send_bit(input bit b, input bit allow_en, input bit w40);
        int gap;
        sclk_posedge = 1'b1;
        miso = b;
        tick();
        sclk_posedge = 1'b0;
        miso = 1'($urandom);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            // en while busy must be ignored
            if (allow_en && $urandom_range(0, 3) == 0) begin
                if (w40) en40 = 1'b1; else en8 = 1'b1;
            end
            tick();
            en8 = 1'b0;
            en40 = 1'b0;
        end
    endtask

    task automatic run(input bit w40, input bit coincident, input string tag);
        int          v0, nv;
        bit          eto;
        logic [39:0] ed;
        ed = w40 ? exp_data40 : exp_data8;
        model(w40 ? 40 : 8, ed, eto, nv);
        v0 = w40 ? vcnt40 : vcnt8;

        if (w40) en40 = 1'b1; else en8 = 1'b1;
        sclk_posedge = coincident;
        miso = coincident ? 1'b0 : 1'($urandom);
        tick();
        en8 = 1'b0;
        en40 = 1'b0;
        sclk_posedge = 1'b0;
        check({tag, "_to_clr"}, w40 ? to40 : to8, 1'b0);
        check({tag, "_busy"}, w40 ? done40 : done8, 1'b0);

        foreach (stim[i]) send_bit(stim[i], i < stim.size() - 1, w40);
        tick();
        tick();

        check({tag, "_nvalid"}, (w40 ? vcnt40 : vcnt8) - v0, nv);
        check({tag, "_data"}, w40 ? data40 : {32'h0, data8}, ed);
        check({tag, "_timed_out"}, w40 ? to40 : to8, eto);
        check({tag, "_done"}, w40 ? done40 : done8, 1'b1);
        if (w40) begin exp_data40 = ed; exp_to40 = eto; end
        else     begin exp_data8  = ed; exp_to8  = eto; end
    endtask

    initial begin
        int          v0;
        int          ones;
        logic [39:0] w;

        reset = 1'b1; sclk_posedge = 1'b0; en8 = 1'b0; en40 = 1'b0; miso = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_data", {32'h0, data8}, 40'h0);
        check("rst_valid", valid8, 1'b0);
        check("rst_to", to8, 1'b0);
        check("rst_done", done8, 1'b1);
        check("rst_data40", data40, 40'h0);

        // 1: three idle ones then 0000_0001
        stim = {1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        run(1'b0, 1'b0, "t1");
        check("t1_val", {32'h0, data8}, 40'h01);

        // 2: stuck high -> timeout, data keeps 8'h01
        build(TO, '0, 8);
        run(1'b0, 1'b0, "t2");
        check("t2_keep", {32'h0, data8}, 40'h01);

        // 3: TO-1 ones then start bit is accepted
        build(TO - 1, 40'h05, 8);
        run(1'b0, 1'b0, "t3");
        check("t3_val", {32'h0, data8}, 40'h05);

        // 4: reset mid-receive aborts silently
        v0 = vcnt8;
        en8 = 1'b1;
        tick();
        en8 = 1'b0;
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t4_rst_data", {32'h0, data8}, 40'h0);
        check("t4_rst_nvalid", vcnt8 - v0, 0);
        check("t4_rst_done", done8, 1'b1);
        check("t4_rst_to", to8, 1'b0);
        exp_data8 = '0;
        exp_data40 = '0;
        build(0, 40'h00, 8);
        run(1'b0, 1'b0, "t4");

        // 5: strobe coincident with en (MISO=0) is not sampled
        build(0, 40'h7F, 8);
        run(1'b0, 1'b1, "t5");
        check("t5_val", {32'h0, data8}, 40'h7F);

        // 6: 40-bit response after a timeout
        build(TO, '0, 40);
        run(1'b1, 1'b0, "t6a");
        check("t6a_to", to40, 1'b1);
        build(3, 40'h01_0000_01AA, 40);
        run(1'b1, 1'b0, "t6");
        check("t6_val", data40, 40'h01_0000_01AA);

        // randomized transactions
        for (int n = 0; n < 24; n++) begin
            ones = $urandom_range(0, TO);
            w = {$urandom, $urandom};
            w[7] = 1'b0;
            build(ones, w, 8);
            run(1'b0, 1'($urandom_range(0, 3) == 0), "r8");
        end
        for (int n = 0; n < 6; n++) begin
            ones = $urandom_range(0, TO);
            w = {$urandom, $urandom};
            w[39] = 1'b0;
            build(ones, w, 40);
            run(1'b1, 1'b0, "r40");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
